cpu_handshake_tx: RTL
=====================

# cpu_handshake_tx

CPU-side transmitter that feeds the peripheral receiver over its `per_send`/`per_ack`/`in_per_dados` interface. It buffers 4-bit words written by the CPU in a small FIFO and sends them one at a time using a four-phase (return-to-zero) send/ack handshake. It sits directly upstream of the peripheral, on the `cpu_clk` domain. `per_ack` arrives from the peripheral clock domain.

## Interface
- `DEPTH`, 4: FIFO entries. Must be a power of two, ≥2.
- `CNT_W`, 8: width of `sent_count`.

- `cpu_clk`  in  1  CPU clock; all state changes on the rising edge.
- `cpu_rst`  in  1  reset. Asynchronous, active-high.
- `wr_en`  in  1  push `wr_data` into the FIFO this cycle.
- `wr_data`  in  4  word to transmit.
- `full`  out  1  FIFO holds `DEPTH` words.
- `empty`  out  1  FIFO holds 0 words.
- `busy`  out  1  FSM is not in IDLE.
- `per_send`  out  1  handshake request to the peripheral.
- `per_ack`  in  1  handshake acknowledge from the peripheral (asynchronous to `cpu_clk`).
- `out_per_dados`  out  4  data bus; connects to the peripheral's `in_per_dados`.
- `sent_count`  out  CNT_W  number of completed transfers, modulo 2^CNT_W.

## Operation
- Reset values:
  - `per_send`=0, `out_per_dados`=4'h0, `sent_count`=0, `busy`=0.
  - `empty`=1, `full`=0.
  - FIFO pointers and occupancy cleared; FSM in IDLE; ack synchronizer flops cleared.
- FIFO behaviour:
  - Circular buffer with log2(DEPTH)-bit pointers and an occupancy counter of log2(DEPTH)+1 bits. Pointers wrap naturally.
  - A write while `full` is dropped. This holds even if a pop happens in the same cycle. No state changes for the dropped write.
  - A simultaneous push and pop on a non-full FIFO leaves occupancy unchanged.
- `ack_s` is the internal view of `per_ack`; its source is set by the `Configuration` macro.
- FSM states:
  - IDLE
    - If `!empty`: pop the head word into `out_per_dados`, set `per_send`=1, go to SEND.
    - Otherwise stay in IDLE.
  - SEND
    - Hold `per_send`=1 and `out_per_dados` stable.
    - On `ack_s`=1: set `per_send`=0, increment `sent_count` (wraps from all-ones to 0), go to RELEASE.
  - RELEASE
    - Hold `out_per_dados` stable; `per_send`=0.
    - On `ack_s`=0: go to IDLE.
- Timeouts: none. The FSM waits indefinitely in SEND or RELEASE.
- `out_per_dados` changes only on the IDLE→SEND transition.
- If `per_ack` is already high when IDLE is left, SEND exits on the first cycle `ack_s`=1. The peripheral must not do this; the bench checks that the block does not hang.

## Timing
- Write to an empty FIFO at edge N → `empty`=0 after N. IDLE pops at edge N+1, so `per_send`=1 and the data are valid after N+1.
- `ack_s` rises at edge K → `per_send`=0 and `sent_count`+1 after K.
- `ack_s` falls at edge M → IDLE after M. If the FIFO is non-empty, the next `per_send`=1 follows after M+1.
- Minimum spacing between `per_send` rising edges: 3 cycles plus the ack latency.
- `full`, `empty`, `busy` are registered-state decodes; they update in the same cycle as the state change.
- Reset asserted mid-handshake: `per_send` drops to 0 immediately (asynchronously). Buffered words are discarded and `sent_count` returns to 0.

## Configuration
- `CPU_TX_ACK_SYNC_EN` defined:
  - `ack_s` is `per_ack` passed through a two-flop synchronizer clocked by `cpu_clk` and reset by `cpu_rst`.
  - Adds 2 cycles of ack latency in each direction.
- Not defined:
  - `ack_s` = `per_ack` directly. Zero added latency.
  - Legal only when `per_clk` and `cpu_clk` are the same clock.

## Test plan
- Reset and single word:
  - Stimulus: after reset, write 4'hA. Peripheral model raises ack 2 cycles after `per_send`, then drops it 1 cycle after `per_send` falls.
  - Required response: `out_per_dados`=4'hA for the whole request, `per_send` low once ack is seen, `sent_count`=1, `busy`=0 at the end.
- Burst and fill, with `DEPTH`=4 and the ack withheld:
  - Stimulus: write 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6 back-to-back.
  - Required response: 4'h1 is popped, 4'h2–4'h5 fill the FIFO, `full`=1, and 4'h6 is dropped.
  - Then release the ack: transfers 1,2,3,4,5 occur in order and `sent_count`=5.
- Wrap-around:
  - Stimulus: 10 sequential write/transfer pairs of 4'h0 through 4'h9.
  - Required response: all received in order; pointers wrap with no loss.
- Counter wrap, with `CNT_W`=2:
  - Stimulus: 5 transfers.
  - Required response: `sent_count` reads 1,2,3,0,1.
- Reset mid-handshake:
  - Stimulus: assert `cpu_rst` while in SEND with 2 words buffered.
  - Required response: `per_send`=0 immediately; `empty`=1 and `sent_count`=0; no transfer after reset is released.
- Slow ack, run with and without `CPU_TX_ACK_SYNC_EN`:
  - Stimulus: ack delayed by 7 cycles.
  - Required response: `per_send` and the data stay stable until the ack is seen. Cycle latency matches the Timing section for both builds (+2 cycles per edge with the synchronizer).

Source files
------------

// File: rtl/cpu_handshake_tx.sv
// CPU-side transmitter: 4-bit word FIFO drained over a four-phase per_send/per_ack handshake.
// Define CPU_TX_ACK_SYNC_EN to pass per_ack through a two-flop cpu_clk synchronizer.
module cpu_handshake_tx #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             wr_en,
    input  logic [3:0]       wr_data,
    output logic             full,
    output logic             empty,
    output logic             busy,
    output logic             per_send,
    input  logic             per_ack,
    output logic [3:0]       out_per_dados,
    output logic [CNT_W-1:0] sent_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_RELEASE} state_t;

    state_t           state_q;
    logic [3:0]       mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             send_q;
    logic [3:0]       data_q;
    logic [CNT_W-1:0] sent_q;
    logic             push;
    logic             pop;
    logic             ack_s;

    assign full          = (count_q == (AW+1)'(DEPTH));
    assign empty         = (count_q == '0);
    assign busy          = (state_q != S_IDLE);
    assign per_send      = send_q;
    assign out_per_dados = data_q;
    assign sent_count    = sent_q;

    // A write while full is dropped even if a pop frees a slot in the same cycle.
    assign push = wr_en && !full;
    assign pop  = (state_q == S_IDLE) && !empty;

`ifdef CPU_TX_ACK_SYNC_EN
    logic [1:0] ack_sync_q;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[0], per_ack};
        end
    end

    assign ack_s = ack_sync_q[1];
`else
    assign ack_s = per_ack;
`endif

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q <= S_IDLE;
            send_q  <= 1'b0;
            data_q  <= '0;
            sent_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        data_q  <= mem_q[rd_ptr_q];
                        send_q  <= 1'b1;
                        state_q <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (ack_s) begin
                        send_q  <= 1'b0;
                        sent_q  <= sent_q + CNT_W'(1);
                        state_q <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!ack_s) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    send_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule
